atm_session_ctrl: RTL

Parametrised multi-account ATM session controller. It sequences card insertion, PIN entry, transaction selection, balance update and card ejection. Added over the single-account controller: per-account balance and PIN storage, PIN retry with account lockout, inactivity timeout, insufficient-funds and overflow checking, and card-removal abort. The block sits between the card/keypad front end and the display/dispenser logic.

---
 rtl/atm_session_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/atm_session_ctrl.sv
// Multi-account ATM session controller: card/PIN handling, balance transactions,
// lockout, inactivity timeout and card-removal abort for NUM_ACCTS accounts.
module atm_session_ctrl #(
  parameter int                 BAL_W     = 32,
  parameter int                 PIN_W     = 4,
  parameter int                 NUM_ACCTS = 4,
  parameter int                 MAX_TRIES = 3,
  parameter int                 TIMEOUT   = 1000,
  parameter logic [BAL_W-1:0]   INIT_BAL  = 32'h000F4240,
  parameter logic [PIN_W-1:0]   INIT_PIN  = 4'b1010,
  localparam int                AW        = $clog2(NUM_ACCTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_in,
  input  logic [AW-1:0]    card_id,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [BAL_W-1:0] amount,
  output logic             busy,
  output logic [BAL_W-1:0] balance_out,
  output logic             balance_valid,
  output logic             op_done,
  output logic [2:0]       err_code,
  output logic             eject_card,
  output logic             card_retained
);

  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_ENTER_PIN   = 4'd1;
  localparam logic [3:0] S_CHOOSE_OP   = 4'd2;
  localparam logic [3:0] S_DEPOSIT     = 4'd3;
  localparam logic [3:0] S_WITHDRAW    = 4'd4;
  localparam logic [3:0] S_UPDATE      = 4'd5;
  localparam logic [3:0] S_DISPLAY     = 4'd6;
  localparam logic [3:0] S_EJECT       = 4'd7;
  localparam logic [3:0] S_RETAIN      = 4'd8;
  localparam logic [3:0] S_WAIT_REMOVE = 4'd9;

  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT - 1);

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_PIN    = 3'd1;
  localparam logic [2:0] ERR_LOCKED = 3'd2;
  localparam logic [2:0] ERR_TMO    = 3'd3;
  localparam logic [2:0] ERR_FUNDS  = 3'd4;
  localparam logic [2:0] ERR_OVF    = 3'd5;

  logic [3:0]           state;
  logic [AW-1:0]        acct;
  logic [TW-1:0]        tries;
  logic [CW-1:0]        tmo_cnt;
  logic [BAL_W-1:0]     amt_q;
  logic [BAL_W-1:0]     new_bal;
  logic [BAL_W-1:0]     bal     [NUM_ACCTS];
  logic [PIN_W-1:0]     pin_mem [NUM_ACCTS];
  logic [NUM_ACCTS-1:0] lock;

  logic [BAL_W-1:0] cur_bal;
  logic [BAL_W:0]   dep_sum;
  logic             card_removed;

  assign busy    = (state != S_IDLE);
  assign cur_bal = bal[acct];
  assign dep_sum = {1'b0, cur_bal} + {1'b0, amt_q};

  // UPDATE must always commit, so a pulled card is only honoured outside it
  assign card_removed = !card_in && (state != S_IDLE) && (state != S_UPDATE) &&
                        (state != S_WAIT_REMOVE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      acct          <= '0;
      tries         <= '0;
      tmo_cnt       <= '0;
      amt_q         <= '0;
      new_bal       <= '0;
      lock          <= '0;
      balance_out   <= '0;
      balance_valid <= 1'b0;
      op_done       <= 1'b0;
      err_code      <= ERR_NONE;
      eject_card    <= 1'b0;
      card_retained <= 1'b0;
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal[i]     <= INIT_BAL;
        pin_mem[i] <= INIT_PIN;
      end
    end else begin
      balance_valid <= 1'b0;
      op_done       <= 1'b0;
      eject_card    <= 1'b0;
      if (card_removed) begin
        state         <= S_IDLE;
        err_code      <= ERR_NONE;
        card_retained <= 1'b0;
        balance_out   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (card_in) begin
              acct    <= card_id;
              tries   <= '0;
              tmo_cnt <= '0;
              if (lock[card_id]) begin
                state    <= S_EJECT;
                err_code <= ERR_LOCKED;
              end else begin
                state <= S_ENTER_PIN;
              end
            end
          end
          S_ENTER_PIN: begin
            if (pin_valid) begin
              tmo_cnt <= '0;
              if (pin == pin_mem[acct]) begin
                state    <= S_CHOOSE_OP;
                err_code <= ERR_NONE;
              end else begin
                err_code <= ERR_PIN;
                tries    <= tries + TW'(1);
                if (tries == TRIES_LAST) begin
                  lock[acct] <= 1'b1;
                  state      <= S_RETAIN;
                end
              end
            end else if (tmo_cnt == TMO_LAST) begin
              state    <= S_EJECT;
              err_code <= ERR_TMO;
            end else begin
              tmo_cnt <= tmo_cnt + CW'(1);
            end
          end
          S_CHOOSE_OP: begin
            if (op_valid) begin
              tmo_cnt  <= '0;
              amt_q    <= amount;
              err_code <= ERR_NONE;
              case (op_code)
                2'b00:   state <= S_DISPLAY;
                2'b01:   state <= S_DEPOSIT;
                2'b10:   state <= S_WITHDRAW;
                default: state <= S_EJECT;
              endcase
            end else if (tmo_cnt == TMO_LAST) begin
              state    <= S_EJECT;
              err_code <= ERR_TMO;
            end else begin
              tmo_cnt <= tmo_cnt + CW'(1);
            end
          end
          S_DEPOSIT: begin
            if (dep_sum[BAL_W]) begin
              err_code <= ERR_OVF;
              state    <= S_DISPLAY;
            end else begin
              new_bal <= dep_sum[BAL_W-1:0];
              state   <= S_UPDATE;
            end
          end
          S_WITHDRAW: begin
            if (amt_q > cur_bal) begin
              err_code <= ERR_FUNDS;
              state    <= S_DISPLAY;
            end else begin
              new_bal <= cur_bal - amt_q;
              state   <= S_UPDATE;
            end
          end
          S_UPDATE: begin
            bal[acct] <= new_bal;
            state     <= S_DISPLAY;
          end
          S_DISPLAY: begin
            balance_out   <= cur_bal;
            balance_valid <= 1'b1;
            op_done       <= 1'b1;
            state         <= S_CHOOSE_OP;
          end
          S_EJECT: begin
            eject_card <= 1'b1;
            state      <= S_WAIT_REMOVE;
          end
          S_RETAIN: begin
            card_retained <= 1'b1;
            state         <= S_WAIT_REMOVE;
          end
          S_WAIT_REMOVE: begin
            if (!card_in) begin
              state         <= S_IDLE;
              err_code      <= ERR_NONE;
              card_retained <= 1'b0;
              balance_out   <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
